vga_write_arbiter: RTL and testbench

- Shares the single VGA adapter pixel-write port between three pixel sources:
  - requester 0: screen clear
  - requester 1: note/octave glyph drawer
  - requester 2: key highlight drawer
- Grants the port to one requester at a time for a whole burst, using round-robin order.
- Registers the winner's pixel stream, drops pixels that fall off-screen, and forces release of a hung burst via a watchdog.
- Sits between the drawing blocks and the VGA adapter's x/y/colour/writeEn inputs.

---
 rtl/vga_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter.sv
// Round-robin owner of the single VGA pixel-write port shared by clear, glyph and key drawers.
// Optional macro VGA_ARB_CLEAR_PRIORITY_EN: screen clear (requester 0) wins arbitration and preempts other owners.
module vga_write_arbiter #(
    parameter int unsigned H_RES   = 160,
    parameter int unsigned V_RES   = 120,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  px_valid,
    input  logic [2:0]  px_last,
    input  logic [23:0] px_x,
    input  logic [20:0] px_y,
    input  logic [8:0]  px_colour,
    output logic [2:0]  gnt,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  colour,
    output logic        writeEn,
    output logic        busy,
    output logic [1:0]  owner,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t      r_state;
    logic [15:0] r_wdog;
    logic [2:0]  r_gnt;
    logic [1:0]  r_owner;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_we;
    logic        r_busy;
    logic        r_timeout;

    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic        w_any;
    logic [7:0]  w_x;
    logic [6:0]  w_y;
    logic [2:0]  w_c;
    logic        w_pv;
    logic        w_pl;
    logic        w_rq;
    logic        w_inb;
    logic        w_wd_exp;
    logic        w_preempt;
    logic        w_release;

    // Search starts just past the previous owner, so the one that just released ranks last.
    always_comb begin
        w_win = r_owner;
        w_any = 1'b0;
        w_idx = '0;
        for (int unsigned k = 1; k <= 3; k++) begin
            w_idx = 2'((32'(r_owner) + k) % 3);
            if (!w_any && req[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
`ifdef VGA_ARB_CLEAR_PRIORITY_EN
        if (req[0]) begin
            w_win = 2'd0;
            w_any = 1'b1;
        end
`endif
    end

    always_comb begin
        case (r_owner)
            2'd0: begin
                w_x = px_x[7:0];   w_y = px_y[6:0];   w_c = px_colour[2:0];
                w_pv = px_valid[0]; w_pl = px_last[0]; w_rq = req[0];
            end
            2'd1: begin
                w_x = px_x[15:8];  w_y = px_y[13:7];  w_c = px_colour[5:3];
                w_pv = px_valid[1]; w_pl = px_last[1]; w_rq = req[1];
            end
            default: begin
                w_x = px_x[23:16]; w_y = px_y[20:14]; w_c = px_colour[8:6];
                w_pv = px_valid[2]; w_pl = px_last[2]; w_rq = req[2];
            end
        endcase
    end

    assign w_inb    = (32'(w_x) < H_RES) && (32'(w_y) < V_RES);
    assign w_wd_exp = (r_wdog == 16'(TIMEOUT - 1));
`ifdef VGA_ARB_CLEAR_PRIORITY_EN
    // Pixels arrive one per cycle, so every cycle is a pixel boundary; any pixel presented now is still written.
    assign w_preempt = (r_owner != 2'd0) && req[0];
`else
    assign w_preempt = 1'b0;
`endif
    assign w_release = (w_pv && w_pl) || !w_rq || w_wd_exp || w_preempt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_wdog    <= '0;
            r_gnt     <= '0;
            r_owner   <= 2'd2;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we   <= 1'b0;
                    r_wdog <= '0;
                    if (w_any) begin
                        r_gnt   <= 3'b001 << w_win;
                        r_owner <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_we <= w_pv && w_inb;
                    if (w_pv && w_inb) begin
                        r_x      <= w_x;
                        r_y      <= w_y;
                        r_colour <= w_c;
                    end
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_wdog  <= '0;
                        r_state <= S_RELEASE;
                        if (w_wd_exp) r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                S_RELEASE: begin
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign owner        = r_owner;
    assign x_out        = r_x;
    assign y_out        = r_y;
    assign colour       = r_colour;
    assign writeEn      = r_we;
    assign busy         = r_busy;
    assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: vector table for arbitration/bounds, scoreboard for pixel writes.
module tb_vga_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  px_valid;
    logic [2:0]  px_last;
    logic [23:0] px_x;
    logic [20:0] px_y;
    logic [8:0]  px_colour;
    logic [2:0]  gnt;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout_flag;

    vga_write_arbiter #(.H_RES(160), .V_RES(120), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .req(req), .px_valid(px_valid), .px_last(px_last),
        .px_x(px_x), .px_y(px_y), .px_colour(px_colour), .gnt(gnt), .x_out(x_out),
        .y_out(y_out), .colour(colour), .writeEn(writeEn), .busy(busy), .owner(owner),
        .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] pv;
        logic [2:0] pl;
        logic [1:0] src;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       wr;
        logic [2:0] gnt;
        logic       busy;
        logic [1:0] own;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         cyc;
    } px_t;

    px_t  sb[$];
    px_t  mon_e;
    vec_t vecs[12];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Pixel goes into slot src; other slots carry in-bounds junk so a wrong slice shows up.
    task automatic drive(input logic [2:0] r, input logic [2:0] pv, input logic [2:0] pl,
                         input logic [1:0] src, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic wr);
        req       = r;
        px_valid  = pv;
        px_last   = pl;
        px_x      = {3{8'd77}};
        px_y      = {3{7'd33}};
        px_colour = {3{3'd7}};
        px_x[8*src +: 8]      = x;
        px_y[7*src +: 7]      = y;
        px_colour[3*src +: 3] = c;
        if (wr) sb.push_back('{x, y, c, cyc + 1});
    endtask

    task automatic wait_grant(output int cnt);
        cnt = 0;
        while (gnt == 3'b000 && cnt < 10) begin
            tick();
            cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 1) begin
            n_chk++;
            if ($countones(gnt) <= 1) n_pass++;
            else $display("FAIL gnt_onehot: got %b required at most one bit", gnt);
        end
        if (writeEn === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL write_unexpected: got x=%0d y=%0d c=%0d at cycle %0d required no write",
                         x_out, y_out, colour, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (x_out === mon_e.x && y_out === mon_e.y && colour === mon_e.c && cyc == mon_e.cyc)
                    n_pass++;
                else
                    $display("FAIL pixel: got (%0d,%0d,%0d)@%0d required (%0d,%0d,%0d)@%0d",
                             x_out, y_out, colour, cyc, mon_e.x, mon_e.y, mon_e.c, mon_e.cyc);
            end
        end
    end

    initial begin
        int cnt;
        int hi;

        //          req     pv      pl      src   x       y       c     wr    gnt     busy  own
        vecs[0]  = '{3'b110, 3'b000, 3'b000, 2'd1, 8'd0,   7'd0,   3'd0, 1'b0, 3'b010, 1'b1, 2'd1};
        vecs[1]  = '{3'b110, 3'b011, 3'b000, 2'd1, 8'd12,  7'd5,   3'd2, 1'b1, 3'b010, 1'b1, 2'd1};
        vecs[2]  = '{3'b110, 3'b010, 3'b000, 2'd1, 8'd159, 7'd5,   3'd2, 1'b1, 3'b010, 1'b1, 2'd1};
        vecs[3]  = '{3'b110, 3'b000, 3'b000, 2'd1, 8'd0,   7'd0,   3'd0, 1'b0, 3'b010, 1'b1, 2'd1};
        vecs[4]  = '{3'b110, 3'b010, 3'b000, 2'd1, 8'd200, 7'd5,   3'd2, 1'b0, 3'b010, 1'b1, 2'd1};
        vecs[5]  = '{3'b110, 3'b010, 3'b000, 2'd1, 8'd14,  7'd120, 3'd2, 1'b0, 3'b010, 1'b1, 2'd1};
        vecs[6]  = '{3'b110, 3'b010, 3'b010, 2'd1, 8'd14,  7'd5,   3'd2, 1'b1, 3'b000, 1'b1, 2'd1};
        vecs[7]  = '{3'b110, 3'b000, 3'b000, 2'd1, 8'd0,   7'd0,   3'd0, 1'b0, 3'b000, 1'b0, 2'd1};
        vecs[8]  = '{3'b110, 3'b000, 3'b000, 2'd2, 8'd0,   7'd0,   3'd0, 1'b0, 3'b100, 1'b1, 2'd2};
        vecs[9]  = '{3'b000, 3'b100, 3'b000, 2'd2, 8'd30,  7'd119, 3'd5, 1'b1, 3'b000, 1'b1, 2'd2};
        vecs[10] = '{3'b000, 3'b000, 3'b000, 2'd2, 8'd0,   7'd0,   3'd0, 1'b0, 3'b000, 1'b0, 2'd2};
        vecs[11] = '{3'b000, 3'b000, 3'b000, 2'd2, 8'd0,   7'd0,   3'd0, 1'b0, 3'b000, 1'b0, 2'd2};

        reset = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_we", 32'(writeEn), 32'd0);
        chk("rst_xyc", {13'd0, x_out, y_out, colour, busy}, 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        chk("rst_owner", 32'(owner), 32'd2);

        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].req, vecs[i].pv, vecs[i].pl, vecs[i].src,
                  vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].wr);
            tick();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].own));
        end
        chk("hold_xyc", {14'd0, x_out, y_out, colour}, {14'd0, 8'd30, 7'd119, 3'd5});

        // Round robin with everyone requesting: 0,1,2,0,1,2 and a RELEASE+IDLE gap between owners.
        drive(3'b111, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            wait_grant(cnt);
            if (b > 0) chk($sformatf("rr%0d_gap", b), 32'(cnt), 32'd2);
            chk($sformatf("rr%0d_gnt", b), 32'(gnt), 32'(3'b001 << (b % 3)));
            for (int p = 0; p < 4; p++) begin
                drive((b == 5 && p == 3) ? 3'b100 : 3'b111, 3'(3'b001 << (b % 3)),
                      (p == 3) ? 3'(3'b001 << (b % 3)) : 3'b000, 2'(b % 3),
                      8'(b * 4 + p), 7'(b), 3'(b % 3), 1'b1);
                tick();
            end
            chk($sformatf("rr%0d_rel", b), 32'(gnt), 32'd0);
            drive((b == 5) ? 3'b100 : 3'b111, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        end

        // Requester 2 never sends last: watchdog forces release after 50 grant cycles.
        wait_grant(cnt);
        chk("to_gnt", 32'(gnt), 32'b100);
        chk("to_flag_before", 32'(timeout_flag), 32'd0);
        hi = 0;
        while (gnt != 3'b000 && hi < 200) begin
            hi++;
            tick();
        end
        chk("to_grant_cycles", 32'(hi), 32'd50);
        chk("to_flag_set", 32'(timeout_flag), 32'd1);
        drive(3'b000, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        repeat (4) tick();
        chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
        chk("to_idle_busy", 32'(busy), 32'd0);

        // Reset lands mid-burst from requester 1.
        drive(3'b010, 3'b000, 3'b000, 2'd1, 8'd0, 7'd0, 3'd0, 1'b0);
        wait_grant(cnt);
        chk("mr_gnt", 32'(gnt), 32'b010);
        for (int p = 0; p < 5; p++) begin
            drive(3'b010, 3'b010, 3'b000, 2'd1, 8'(50 + p), 7'd60, 3'd3, 1'b1);
            tick();
        end
        reset = 1'b0;
        drive(3'b010, 3'b010, 3'b000, 2'd1, 8'd55, 7'd60, 3'd3, 1'b0);
        tick();
        chk("mr_gnt_drop", 32'(gnt), 32'd0);
        chk("mr_we", 32'(writeEn), 32'd0);
        chk("mr_owner", 32'(owner), 32'd2);
        chk("mr_tflag", 32'(timeout_flag), 32'd0);
        reset = 1'b1;
        drive(3'b011, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        wait_grant(cnt);
        chk("mr_regrant", 32'(gnt), 32'b001);

        // Requester 0 finishes; requester 2 starts a burst and requester 0 asks again mid-burst.
        drive(3'b100, 3'b001, 3'b001, 2'd0, 8'd1, 7'd1, 3'd1, 1'b1);
        tick();
        wait_grant(cnt);
        chk("pe_gnt2", 32'(gnt), 32'b100);
        for (int p = 0; p < 2; p++) begin
            drive(3'b100, 3'b100, 3'b000, 2'd2, 8'(70 + p), 7'd70, 3'd6, 1'b1);
            tick();
        end
        drive(3'b101, 3'b100, 3'b000, 2'd2, 8'd72, 7'd70, 3'd6, 1'b1);
        tick();
`ifdef VGA_ARB_CLEAR_PRIORITY_EN
        chk("pe_preempt_rel", 32'(gnt), 32'd0);
        drive(3'b101, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        wait_grant(cnt);
        chk("pe_clear_gnt", 32'(gnt), 32'b001);
        drive(3'b100, 3'b001, 3'b001, 2'd0, 8'd2, 7'd2, 3'd2, 1'b1);
        tick();
        drive(3'b100, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        wait_grant(cnt);
        chk("pe_regrant2", 32'(gnt), 32'b100);
        drive(3'b000, 3'b100, 3'b100, 2'd2, 8'd80, 7'd80, 3'd4, 1'b1);
        tick();
`else
        chk("pe_no_preempt", 32'(gnt), 32'b100);
        for (int p = 3; p < 6; p++) begin
            drive(3'b101, 3'b100, (p == 5) ? 3'b100 : 3'b000, 2'd2, 8'(70 + p), 7'd70, 3'd6, 1'b1);
            tick();
        end
        drive(3'b001, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        wait_grant(cnt);
        chk("pe_then_clear", 32'(gnt), 32'b001);
        drive(3'b000, 3'b001, 3'b001, 2'd0, 8'd2, 7'd2, 3'd2, 1'b1);
        tick();
`endif
        drive(3'b000, 3'b000, 3'b000, 2'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        repeat (3) tick();
        chk("end_gnt", 32'(gnt), 32'd0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
